// File: rtl/iob_eth_tx_pkg.sv
// ============================================================================
// Module  : iob_eth_tx_pkg
// Brief   : State encoding and framing/CRC constants for the MII TX engine.
// Revision: 1.0
// ============================================================================
`default_nettype none

package iob_eth_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SFD  = 3'd2,
    ST_DATA = 3'd3,
    ST_CRC  = 3'd4,
    ST_IFG  = 3'd5
  } tx_state_t;

  localparam logic [4:0]  c_preamble_nibbles = 5'd15;
  localparam logic [3:0]  c_preamble_nibble  = 4'h5;
  localparam logic [3:0]  c_sfd_nibble       = 4'hD;
  localparam logic [4:0]  c_crc_nibbles      = 5'd8;
  localparam logic [4:0]  c_ifg_cycles       = 5'd24;
  localparam logic [10:0] c_min_payload      = 11'd60;
  // Bit-reflected form of 0x04C11DB7, LSB-first shifting.
  localparam logic [31:0] c_crc_poly         = 32'hEDB88320;
  localparam logic [31:0] c_crc_init         = 32'hFFFFFFFF;

endpackage

`default_nettype wire

// File: rtl/iob_eth_crc32_nibble.sv
// ============================================================================
// Module  : iob_eth_crc32_nibble
// Brief   : Combinational next-state of the reflected Ethernet CRC-32, 4 bits.
// Revision: 1.0
// ============================================================================
`default_nettype none

module iob_eth_crc32_nibble
  import iob_eth_tx_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [3:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] w_acc;

  always_comb begin
    w_acc = i_crc ^ {28'd0, i_data};
    for (int i = 0; i < 4; i++) begin
      w_acc = w_acc[0] ? ((w_acc >> 1) ^ c_crc_poly) : (w_acc >> 1);
    end
  end

  assign o_crc = w_acc;

endmodule

`default_nettype wire

// File: rtl/iob_eth_tx.sv
// ============================================================================
// Module  : iob_eth_tx
// Brief   : MII transmit engine: preamble, SFD, payload, optional FCS, IFG.
//           Define IOB_ETH_TX_PAD_EN to zero-pad short payloads to 60 bytes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module iob_eth_tx
  import iob_eth_tx_pkg::*;
#(
  parameter int BUFFER_W = 11
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_n_i,
  input  logic                send_i,
  input  logic                crc_en_i,
  input  logic [10:0]         nbytes_i,
  output logic                ready_o,
  output logic [BUFFER_W-1:0] buf_addr_o,
  input  logic [7:0]          buf_data_i,
  output logic                tx_en_o,
  output logic [3:0]          txd_o
);

  localparam logic [BUFFER_W-1:0] c_addr_one = {{(BUFFER_W-1){1'b0}}, 1'b1};

  tx_state_t           r_state;
  logic                r_send_q;
  logic                r_ready;
  logic                r_tx_en;
  logic [3:0]          r_txd;
  logic [BUFFER_W-1:0] r_buf_addr;
  logic [4:0]          r_cnt;
  logic [10:0]         r_nbytes;
  logic [10:0]         r_byte;
  logic                r_hi;
  logic                r_crc_en;
  logic [31:0]         r_crc;

  logic [10:0] w_len;
  logic [10:0] w_cur_idx;
  logic        w_is_pad;
  logic        w_last;
  logic        w_start;
  logic [7:0]  w_byte;
  logic [3:0]  w_nibble;
  logic [31:0] w_crc_next;

  // r_byte counts bytes whose low nibble has gone out; a high nibble belongs
  // to the byte before it.
  assign w_cur_idx = r_hi ? (r_byte - 11'd1) : r_byte;
`ifdef IOB_ETH_TX_PAD_EN
  assign w_len = (r_nbytes < c_min_payload) ? c_min_payload : r_nbytes;
`else
  assign w_len = r_nbytes;
`endif
  assign w_is_pad = (w_cur_idx >= r_nbytes);
  assign w_byte   = w_is_pad ? 8'h00 : buf_data_i;
  assign w_nibble = r_hi ? w_byte[7:4] : w_byte[3:0];
  assign w_last   = !r_hi && (r_byte == w_len);
  assign w_start  = (r_state == ST_IDLE) && send_i && !r_send_q;

  iob_eth_crc32_nibble u_crc (
    .i_crc  (r_crc),
    .i_data (w_nibble),
    .o_crc  (w_crc_next)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state    <= ST_IDLE;
      r_send_q   <= 1'b1;
      r_ready    <= 1'b1;
      r_tx_en    <= 1'b0;
      r_txd      <= 4'h0;
      r_buf_addr <= '0;
      r_cnt      <= 5'd0;
      r_nbytes   <= 11'd0;
      r_byte     <= 11'd0;
      r_hi       <= 1'b0;
      r_crc_en   <= 1'b0;
      r_crc      <= c_crc_init;
    end else if (cke_i) begin
      r_send_q <= send_i;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state    <= ST_PRE;
            r_ready    <= 1'b0;
            r_tx_en    <= 1'b1;
            r_txd      <= c_preamble_nibble;
            r_cnt      <= 5'd1;
            r_buf_addr <= '0;
            r_nbytes   <= nbytes_i;
            r_crc_en   <= crc_en_i;
            r_crc      <= c_crc_init;
            r_byte     <= 11'd0;
            r_hi       <= 1'b0;
          end
        end
        ST_PRE: begin
          if (r_cnt == c_preamble_nibbles) begin
            r_state <= ST_SFD;
            r_txd   <= c_sfd_nibble;
          end else begin
            r_txd <= c_preamble_nibble;
            r_cnt <= r_cnt + 5'd1;
          end
        end
        ST_SFD, ST_DATA: begin
          if (w_last) begin
            r_cnt <= 5'd1;
            if (r_crc_en) begin
              r_state <= ST_CRC;
              r_txd   <= ~r_crc[3:0];
              r_crc   <= {4'h0, r_crc[31:4]};
            end else begin
              r_state <= ST_IFG;
              r_tx_en <= 1'b0;
              r_txd   <= 4'h0;
            end
          end else begin
            r_state <= ST_DATA;
            r_txd   <= w_nibble;
            r_crc   <= w_crc_next;
            r_hi    <= !r_hi;
            // Advancing on the low nibble leaves the next byte's read in flight.
            if (!r_hi) begin
              r_byte <= r_byte + 11'd1;
              if (!w_is_pad) r_buf_addr <= r_buf_addr + c_addr_one;
            end
          end
        end
        ST_CRC: begin
          if (r_cnt == c_crc_nibbles) begin
            r_state <= ST_IFG;
            r_tx_en <= 1'b0;
            r_txd   <= 4'h0;
            r_cnt   <= 5'd1;
          end else begin
            r_txd <= ~r_crc[3:0];
            r_crc <= {4'h0, r_crc[31:4]};
            r_cnt <= r_cnt + 5'd1;
          end
        end
        ST_IFG: begin
          if (r_cnt == c_ifg_cycles) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready_o    = r_ready;
  assign tx_en_o    = r_tx_en;
  assign txd_o      = r_txd;
  assign buf_addr_o = r_buf_addr;

endmodule

`default_nettype wire

// File: tb/tb_iob_eth_tx.sv
// ============================================================================
// Module  : tb_iob_eth_tx
// Brief   : Randomized self-checking bench for iob_eth_tx against a byte-level
//           frame model. Honours IOB_ETH_TX_PAD_EN. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_iob_eth_tx;

  localparam int BUFFER_W = 11;

  logic                clk    = 1'b0;
  logic                cke    = 1'b1;
  logic                arst_n = 1'b1;
  logic                send   = 1'b0;
  logic                crc_en = 1'b0;
  logic [10:0]         nbytes = 11'd0;
  logic                ready;
  logic                tx_en;
  logic [3:0]          txd;
  logic [BUFFER_W-1:0] buf_addr;
  logic [7:0]          buf_data = 8'h00;
  logic [7:0]          mem [0:2047];

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];

  always #5 clk = ~clk;

  // Frame buffer with one cycle of read latency.
  always @(posedge clk) if (cke) buf_data <= mem[buf_addr];

  iob_eth_tx #(.BUFFER_W(BUFFER_W)) dut (
    .clk_i      (clk),
    .cke_i      (cke),
    .arst_n_i   (arst_n),
    .send_i     (send),
    .crc_en_i   (crc_en),
    .nbytes_i   (nbytes),
    .ready_o    (ready),
    .buf_addr_o (buf_addr),
    .buf_data_i (buf_data),
    .tx_en_o    (tx_en),
    .txd_o      (txd)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected on-wire nibble stream for a frame of n bytes from mem.
  task automatic build_expected(input int n, input bit crc);
    logic [31:0] c;
    logic [7:0]  b;
    int          len;
    exp_q.delete();
    repeat (15) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    len = n;
`ifdef IOB_ETH_TX_PAD_EN
    if (len < 60) len = 60;
`endif
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) begin
      b = (i < n) ? mem[i] : 8'h00;
      exp_q.push_back(b[3:0]);
      exp_q.push_back(b[7:4]);
      c = c ^ {24'd0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    if (crc) begin
      c = ~c;
      for (int i = 0; i < 8; i++) exp_q.push_back(c[4*i +: 4]);
    end
  endtask

  task automatic run_frame(input int n, input bit crc, input bit hold, input bit freeze);
    int                  cyc;
    int                  txc;
    int                  rdy;
    int                  extra;
    bit                  done;
    logic [3:0]          s_txd;
    logic                s_en;
    logic                s_rdy;
    logic [BUFFER_W-1:0] s_addr;
    logic [3:0]          g;
    cyc = 0; txc = 0; rdy = 0; done = 1'b0;
    build_expected(n, crc);
    got_q.delete();
    @(negedge clk);
    nbytes = n[10:0];
    crc_en = crc;
    send   = 1'b1;
    while (!done && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("start_ready", ready, 0);
        chk("start_tx_en", tx_en, 1);
        if (!hold) send = 1'b0;
        nbytes = 11'($urandom);
        crc_en = 1'($urandom);
      end
      if (hold && cyc == 10) send = 1'b0;
      if (hold && cyc == 12) send = 1'b1;
      if (tx_en) begin
        got_q.push_back(txd);
        txc++;
      end
      if (!ready) rdy++;
      else done = 1'b1;
      if (freeze && cyc == 20) begin
        s_txd = txd; s_en = tx_en; s_rdy = ready; s_addr = buf_addr;
        cke = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("freeze_txd", txd, s_txd);
          chk("freeze_tx_en", tx_en, s_en);
          chk("freeze_ready", ready, s_rdy);
          chk("freeze_addr", buf_addr, s_addr);
        end
        cke = 1'b1;
      end
    end
    chk("frame_done_in_budget", done, 1);
    chk("tx_en_cycles", txc, exp_q.size());
    chk("ready_low_cycles", rdy, exp_q.size() + 24);
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 4'h0;
      chk($sformatf("nibble[%0d] n=%0d", i, n), g, exp_q[i]);
      if (g !== exp_q[i]) break;
    end
    if (hold) begin
      extra = 0;
      repeat (30) begin
        @(negedge clk);
        if (tx_en) extra++;
      end
      chk("no_retrigger", extra, 0);
      send = 1'b0;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          extra;
    int          n;
    logic [31:0] fcs;
    string       s;
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);

    // Reset with send already high: must not launch a frame on release.
    send = 1'b1;
    #2 arst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", ready, 1);
    chk("reset_tx_en", tx_en, 0);
    chk("reset_txd", txd, 0);
    chk("reset_addr", buf_addr, 0);
    arst_n = 1'b1;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_en) extra++;
    end
    chk("no_start_at_release", extra, 0);
    send = 1'b0;
    @(negedge clk);

    // T1: single byte, no FCS
    mem[0] = 8'hAB;
    run_frame(1, 1'b0, 1'b0, 1'b0);

    // T2: check value of the standard CRC-32 test vector
    s = "123456789";
    for (int i = 0; i < 9; i++) mem[i] = s[i];
    run_frame(9, 1'b1, 1'b0, 1'b0);
`ifndef IOB_ETH_TX_PAD_EN
    fcs = 32'd0;
    if (got_q.size() >= 8)
      for (int i = 0; i < 8; i++) fcs[4*i +: 4] = got_q[got_q.size() - 8 + i];
    chk("t2_fcs", fcs, 32'hCBF43926);
`endif

    // T3: send held high, with a mid-frame re-edge
    run_frame(4, 1'b0, 1'b1, 1'b0);

    // T4: reset during DATA nibble 5
    @(negedge clk);
    nbytes = 11'd20; crc_en = 1'b1; send = 1'b1;
    repeat (21) @(negedge clk);
    send = 1'b0;
    chk("t4_in_frame", tx_en, 1);
    arst_n = 1'b0;
    #1;
    chk("t4_rst_tx_en", tx_en, 0);
    chk("t4_rst_ready", ready, 1);
    chk("t4_rst_txd", txd, 0);
    chk("t4_rst_addr", buf_addr, 0);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(20, 1'b1, 1'b0, 1'b0);

    // T5: short payload with FCS (padded when the feature is built in)
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    run_frame(10, 1'b1, 1'b0, 1'b0);

    // T6: empty payload with FCS
    run_frame(0, 1'b1, 1'b0, 1'b0);

    // Randomized frames, one with a clock-enable freeze
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
      n = (t == 5) ? 300 : int'($urandom_range(0, 80));
      run_frame(n, 1'($urandom), 1'b0, (t == 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
